z80_bus_arbiter: RTL



---
 rtl/z80_bus_arbiter_pkg.sv | 48 ++++
 rtl/z80_bus_arbiter_wait.sv | 41 ++++
 rtl/z80_bus_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/z80_bus_arbiter_pkg.sv
// Shared Z80 bus types, the idle master bus value and the arbiter state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package z80_bus_arbiter_pkg;

    // Master-side outputs of a Z80-style bus master (CPU or DMA).
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        mreqn;
        logic        iorqn;
        logic        rdn;
        logic        wrn;
        logic        inta;
    } Z80MasterBus;

    // Slave response; mwait=1 means the slave is ready.
    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;

    // Bus driven while neither master owns it: all strobes inactive.
    localparam Z80MasterBus Z80_MASTER_IDLE = '{
        addr:    16'h0000,
        dmaster: 8'h00,
        mreqn:   1'b1,
        iorqn:   1'b1,
        rdn:     1'b1,
        wrn:     1'b1,
        inta:    1'b0
    };

    typedef enum logic [2:0] {
        ST_CPU,
        ST_REQ,
        ST_SETTLE,
        ST_DMA,
        ST_REL
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_CPU,
        SEL_DMA,
        SEL_IDLE
    } bus_sel_t;

endpackage

// File: rtl/z80_bus_arbiter_wait.sv
// DMA wait-state generator: inserts WAIT_STATES waits per DMA memory cycle, ORed with slave not-ready.
// Latency: counter loads on the cen edge after mreqn falls; dma_wait is combinational from the counter and mwait.
// Backpressure: dma_wait is the backpressure to the DMA; nothing here is stalled except by cen.
// Ports: clk, rst (async, active-high), cen, enable (DMA owns bus), mreqn (DMA bus), mwait (slave ready), dma_wait.
module z80_wait_gen #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic enable,
    input  logic mreqn,
    input  logic mwait,
    output logic dma_wait
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic       mreqn_d;
    logic [3:0] wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mreqn_d <= 1'b1;
            wcnt    <= 4'd0;
        end else if (cen) begin
            mreqn_d <= mreqn;
            if (!enable) begin
                wcnt <= 4'd0;
            end else if (mreqn_d && !mreqn) begin
                // Falling mreqn marks the start of a DMA memory cycle.
                wcnt <= WAIT_LOAD;
            end else if (wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    assign dma_wait = enable && ((wcnt != 4'd0) || !mwait);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Bus-ownership arbiter: turns a DMA busrq into a Z80 BUSREQ_n/BUSACK_n exchange and muxes CPU/DMA onto the system bus.
// Latency: grant two cycles after the CPU ack is sampled (one idle settle cycle); release one cycle after busrq drops.
// Backpressure: the CPU is held off via cpu_busreq_n, the DMA via dma_busack and dma_wait; cen=0 freezes everything.
// Ports: clk, rst, cen; cpu_busreq_n/cpu_busack_n, cpu_obus/cpu_ibus; dma_busrq/dma_busack/dma_wait,
//        dma_obus/dma_ibus; sys_obus (to decoder/memory), sys_ibus (slave response).
module z80_bus_arbiter
    import z80_bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    output logic        cpu_busreq_n,
    input  logic        cpu_busack_n,
    input  Z80MasterBus cpu_obus,
    output Z80SlaveBus  cpu_ibus,
    input  logic        dma_busrq,
    output logic        dma_busack,
    output logic        dma_wait,
    input  Z80MasterBus dma_obus,
    output Z80SlaveBus  dma_ibus,
    output Z80MasterBus sys_obus,
    input  Z80SlaveBus  sys_ibus
);

    arb_state_t state;
    arb_state_t next_state;
    bus_sel_t   sel;

    // Handshake outputs are flops decoded from next_state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CPU;
            cpu_busreq_n <= 1'b1;
            dma_busack   <= 1'b0;
        end else if (cen) begin
            state        <= next_state;
            cpu_busreq_n <= !(next_state == ST_REQ || next_state == ST_SETTLE || next_state == ST_DMA);
            dma_busack   <= (next_state == ST_DMA);
        end
    end

    always_comb begin
        next_state = state;
        sel        = SEL_IDLE;
        case (state)
            ST_CPU: begin
                sel = SEL_CPU;
                if (dma_busrq) next_state = ST_REQ;
            end
            ST_REQ: begin
                sel = SEL_CPU;
                // A dropped request wins over a coincident ack.
                if (!dma_busrq)         next_state = ST_REL;
                else if (!cpu_busack_n) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                next_state = dma_busrq ? ST_DMA : ST_REL;
            end
            ST_DMA: begin
                sel = SEL_DMA;
                if (!dma_busrq) next_state = ST_REL;
            end
            ST_REL: begin
                if (cpu_busack_n) next_state = ST_CPU;
            end
            default: begin
                next_state = ST_CPU;
            end
        endcase
    end

    always_comb begin
        sys_obus = Z80_MASTER_IDLE;
        case (sel)
            SEL_CPU: sys_obus = cpu_obus;
            SEL_DMA: sys_obus = dma_obus;
            default: sys_obus = Z80_MASTER_IDLE;
        endcase
    end

    // The DMA sees readiness only through dma_wait, so its mwait is tied ready.
    assign cpu_ibus.dslave = sys_ibus.dslave;
    assign cpu_ibus.mwait  = sys_ibus.mwait;
    assign dma_ibus.dslave = sys_ibus.dslave;
    assign dma_ibus.mwait  = 1'b1;

    z80_wait_gen #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .enable   (state == ST_DMA),
        .mreqn    (dma_obus.mreqn),
        .mwait    (sys_ibus.mwait),
        .dma_wait (dma_wait)
    );

endmodule
